vga_sdram_writer: RTL

Framebuffer writer feeding the SDRAM controller's write port; the write-side counterpart of the VGA read path. Accepts a raster-order stream of 4-bit pixels, packs 32 pixels into one 128-bit word, and issues one SDRAM write per word at the word address the VGA read adapter fetches from. A pack register and a pending-write register let pixel intake continue while one write is outstanding.

---
 rtl/vga_sdram_writer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/vga_sdram_writer.sv
// Framebuffer writer: packs a raster stream of 4-bit pixels into 128-bit words
// and issues one SDRAM write per word, with a pack stage and a pending-write stage.
module vga_sdram_writer #(
    parameter int PIXEL_SIZE      = 4,
    parameter int CACHE_LENGTH    = 32,
    parameter int WORDS_PER_FRAME = 9600
) (
    input  logic                               iclk_50,
    input  logic                               ireset_n,
    input  logic                               ipix_valid,
    input  logic [PIXEL_SIZE-1:0]              ipix_data,
    input  logic                               ipix_sof,
    output logic                               opix_ready,
    output logic                               owrite_req,
    output logic [21:0]                        owrite_address,
    output logic [PIXEL_SIZE*CACHE_LENGTH-1:0] owrite_data,
    input  logic                               iwrite_ack,
    output logic                               oframe_done,
    output logic                               odrop
);

    localparam int WORD_W = PIXEL_SIZE * CACHE_LENGTH;
    localparam int K_W    = $clog2(CACHE_LENGTH);

    localparam logic [21:0]    LAST_ADDR = 22'(WORDS_PER_FRAME - 1);
    localparam logic [K_W-1:0] K_LAST    = K_W'(CACHE_LENGTH - 1);
    localparam logic [K_W-1:0] K_ONE     = K_W'(1);

    logic [WORD_W-1:0] r_pack;
    logic [K_W-1:0]    r_k;
    logic              r_pack_full;
    logic [21:0]       r_word_cnt;
    logic              r_req;
    logic [21:0]       r_addr;
    logic [WORD_W-1:0] r_data;
    logic              r_ready;
    logic              r_frame_done;
    logic              r_drop;

    logic [WORD_W-1:0] w_pack_nxt;
    logic [K_W-1:0]    w_k_nxt;
    logic              w_pack_full_nxt;
    logic [21:0]       w_word_cnt_nxt;
    logic              w_req_nxt;
    logic [21:0]       w_addr_nxt;
    logic [WORD_W-1:0] w_data_nxt;
    logic              w_frame_done_nxt;
    logic              w_drop_nxt;

    logic              w_accept;
    logic              w_ack;
    logic              w_pend_free;
    logic              w_complete;
    logic [K_W-1:0]    w_idx;
    logic [WORD_W-1:0] w_pack_in;
    logic [21:0]       w_cnt_inc;

    // Decode the handshakes and build the pack word with the incoming pixel inserted.
    always_comb begin
        w_accept    = ipix_valid & r_ready;
        w_ack       = iwrite_ack & r_req;
        // A request acknowledged on this very edge still occupies the pending slot.
        w_pend_free = ~r_req;
        w_complete  = w_accept & ~ipix_sof & (r_k == K_LAST);
        w_idx       = ipix_sof ? {K_W{1'b0}} : r_k;
        w_pack_in   = ipix_sof ? {WORD_W{1'b0}} : r_pack;
        w_pack_in[int'(w_idx)*PIXEL_SIZE +: PIXEL_SIZE] = ipix_data;
        if (r_word_cnt == LAST_ADDR) begin
            w_cnt_inc = 22'd0;
        end else begin
            w_cnt_inc = r_word_cnt + 22'd1;
        end
    end

    // Next-state selection for the pack, pending-write and counter registers.
    always_comb begin
        w_pack_nxt       = r_pack;
        w_k_nxt          = r_k;
        w_pack_full_nxt  = r_pack_full;
        w_word_cnt_nxt   = r_word_cnt;
        w_req_nxt        = r_req;
        w_addr_nxt       = r_addr;
        w_data_nxt       = r_data;
        w_frame_done_nxt = 1'b0;
        w_drop_nxt       = 1'b0;

        if (w_ack) begin
            w_req_nxt        = 1'b0;
            w_frame_done_nxt = (r_addr == LAST_ADDR);
        end else begin
            w_req_nxt        = r_req;
        end

        if (r_pack_full && w_pend_free) begin
            w_data_nxt      = r_pack;
            w_addr_nxt      = r_word_cnt;
            w_req_nxt       = 1'b1;
            w_word_cnt_nxt  = w_cnt_inc;
            w_k_nxt         = {K_W{1'b0}};
            w_pack_full_nxt = 1'b0;
        end else if (w_accept) begin
            if (ipix_sof) begin
                w_pack_nxt     = w_pack_in;
                w_k_nxt        = K_ONE;
                w_word_cnt_nxt = 22'd0;
                w_drop_nxt     = (r_k != {K_W{1'b0}});
            end else if (w_complete && w_pend_free) begin
                w_pack_nxt     = w_pack_in;
                w_data_nxt     = w_pack_in;
                w_addr_nxt     = r_word_cnt;
                w_req_nxt      = 1'b1;
                w_word_cnt_nxt = w_cnt_inc;
                w_k_nxt        = {K_W{1'b0}};
            end else if (w_complete) begin
                w_pack_nxt      = w_pack_in;
                w_pack_full_nxt = 1'b1;
            end else begin
                w_pack_nxt = w_pack_in;
                w_k_nxt    = r_k + K_ONE;
            end
        end else begin
            w_pack_nxt = r_pack;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge iclk_50) begin
        if (!ireset_n) begin
            r_pack       <= {WORD_W{1'b0}};
            r_k          <= {K_W{1'b0}};
            r_pack_full  <= 1'b0;
            r_word_cnt   <= 22'd0;
            r_req        <= 1'b0;
            r_addr       <= 22'd0;
            r_data       <= {WORD_W{1'b0}};
            r_ready      <= 1'b0;
            r_frame_done <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            r_pack       <= w_pack_nxt;
            r_k          <= w_k_nxt;
            r_pack_full  <= w_pack_full_nxt;
            r_word_cnt   <= w_word_cnt_nxt;
            r_req        <= w_req_nxt;
            r_addr       <= w_addr_nxt;
            r_data       <= w_data_nxt;
            r_ready      <= ~w_pack_full_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_drop       <= w_drop_nxt;
        end
    end

    assign opix_ready     = r_ready;
    assign owrite_req     = r_req;
    assign owrite_address = r_addr;
    assign owrite_data    = r_data;
    assign oframe_done    = r_frame_done;
    assign odrop          = r_drop;

endmodule
